inst_fetch_bridge: RTL and testbench

Instruction-fetch bridge between the CPU core's instruction port (`rom_ce`/`rom_addr`/`rom_data`) and a variable-latency instruction memory that uses a req/ack handshake. It keeps a one-entry fetch buffer. On a hit it returns data in the same cycle. On a miss it raises `stall_req_o` to the pipeline and runs a memory transaction. It also guards against misaligned fetches and against a memory that never acknowledges.

---
 rtl/inst_fetch_bridge.sv | 113 +++++++++++
 tb/tb_inst_fetch_bridge.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_bridge.sv
// Instruction-fetch bridge: one-entry fetch buffer in front of a req/ack
// instruction memory, with misaligned-fetch and ack-timeout protection.
module inst_fetch_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_ce_i,
    input  logic [31:0] rom_addr_i,
    input  logic        flush_i,
    output logic [31:0] rom_data_o,
    output logic        stall_req_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        bus_err_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state;
    logic        buf_valid;
    logic [31:0] buf_addr;
    logic [31:0] buf_data;
    logic [31:0] req_addr;
    logic [7:0]  wait_cnt;
    logic        drop;

    logic aligned;
    logic hit;
    logic misaligned;
    logic miss;

    assign aligned    = (rom_addr_i[1:0] == 2'b00);
    assign hit        = buf_valid && (rom_addr_i == buf_addr);
    assign misaligned = rom_ce_i && !aligned;
    assign miss       = rom_ce_i && aligned && !hit;
    assign mem_addr_o = req_addr;

    always_comb begin
        rom_data_o  = '0;
        stall_req_o = 1'b0;
        if (rst) begin
            if (state == BUSY) begin
                stall_req_o = 1'b1;
            end else if (rom_ce_i && aligned) begin
                if (hit) rom_data_o  = buf_data;
                else     stall_req_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
            req_addr  <= '0;
            wait_cnt  <= '0;
            drop      <= 1'b0;
            mem_req_o <= 1'b0;
            bus_err_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_i) buf_valid <= 1'b0;
                    if (misaligned) bus_err_o <= 1'b1;
                    if (miss) begin
                        req_addr  <= rom_addr_i;
                        wait_cnt  <= '0;
                        state     <= BUSY;
                        mem_req_o <= 1'b1;
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        state     <= IDLE;
                        mem_req_o <= 1'b0;
                        drop      <= 1'b0;
                        // A flush in the ack cycle counts the same as an earlier one.
                        if (drop || flush_i) begin
                            buf_valid <= 1'b0;
                        end else begin
                            buf_addr  <= req_addr;
                            buf_data  <= mem_rdata_i;
                            buf_valid <= 1'b1;
                        end
                    end else if (wait_cnt == LAST_WAIT) begin
                        state     <= IDLE;
                        mem_req_o <= 1'b0;
                        drop      <= 1'b0;
                        buf_addr  <= req_addr;
                        buf_data  <= '0;
                        buf_valid <= 1'b1;
                        bus_err_o <= 1'b1;
                    end else begin
                        if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
                        if (flush_i) begin
                            drop      <= 1'b1;
                            buf_valid <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench for inst_fetch_bridge: reset, miss/hit, zero-wait ack,
// misaligned fetch, timeout, flush and reset during a transaction.
module tb_inst_fetch_bridge;

    logic        clk;
    logic        rst;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic        flush_i;
    logic [31:0] rom_data_o;
    logic        stall_req_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        bus_err_o;

    int tests_run;
    int tests_failed;

    inst_fetch_bridge #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_ce_i    (rom_ce_i),
        .rom_addr_i  (rom_addr_i),
        .flush_i     (flush_i),
        .rom_data_o  (rom_data_o),
        .stall_req_o (stall_req_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .bus_err_o   (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start of a new cycle: inputs are driven right after this returns.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b0; rom_ce_i = 1'b1; rom_addr_i = 32'h0; flush_i = 1'b0;
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            settle();
            tests_run++;
            if (stall_req_o !== 1'b0 || mem_req_o !== 1'b0 || bus_err_o !== 1'b0 ||
                rom_data_o !== 32'h0 || mem_addr_o !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_c%0d: stall=%b req=%b err=%b data=%h addr=%h, want 0 0 0 0 0",
                         c, stall_req_o, mem_req_o, bus_err_o, rom_data_o, mem_addr_o);
            end
        end
        next_cycle();
        rst = 1'b1; rom_ce_i = 1'b0;
    endtask

    task automatic test_miss_hit();
        int stalls;
        logic addr_ok;
        stalls = 0; addr_ok = 1'b1;
        next_cycle();
        rom_ce_i = 1'b1; rom_addr_i = 32'h4;
        settle();
        if (stall_req_o === 1'b1) stalls++;
        tests_run++;
        if (mem_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL miss_detect_req: got %b want 0", mem_req_o);
        end
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            mem_ack_i = (c == 3); mem_rdata_i = (c == 3) ? 32'h34011100 : 32'hFFFF_FFFF;
            rom_addr_i = 32'h4;
            settle();
            if (stall_req_o === 1'b1) stalls++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h4 || rom_data_o !== 32'h0) addr_ok = 1'b0;
        end
        next_cycle();
        mem_ack_i = 1'b0;
        settle();
        if (stall_req_o === 1'b1) stalls++;
        tests_run++;
        if (!addr_ok) begin
            tests_failed++;
            $display("FAIL miss_busy_req_addr: req/addr/data not held at 1/00000004/0 during wait");
        end
        tests_run++;
        if (stalls != 4) begin
            tests_failed++;
            $display("FAIL miss_stall_cycles: got %0d want 4", stalls);
        end
        tests_run++;
        if (rom_data_o !== 32'h34011100 || stall_req_o !== 1'b0 || mem_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL miss_then_hit: data=%h stall=%b req=%b want 34011100 0 0",
                     rom_data_o, stall_req_o, mem_req_o);
        end
        next_cycle();
        settle();
        tests_run++;
        if (mem_req_o !== 1'b0 || rom_data_o !== 32'h34011100 || stall_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL refetch_hit: req=%b data=%h stall=%b want 0 34011100 0",
                     mem_req_o, rom_data_o, stall_req_o);
        end
    endtask

    task automatic test_zero_wait();
        int stalls;
        stalls = 0;
        next_cycle();
        rom_ce_i = 1'b1; rom_addr_i = 32'h10;
        settle();
        if (stall_req_o === 1'b1) stalls++;
        next_cycle();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h3C010101;
        settle();
        if (stall_req_o === 1'b1) stalls++;
        tests_run++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h10) begin
            tests_failed++;
            $display("FAIL zero_wait_req: req=%b addr=%h want 1 00000010", mem_req_o, mem_addr_o);
        end
        next_cycle();
        mem_ack_i = 1'b0;
        settle();
        if (stall_req_o === 1'b1) stalls++;
        tests_run++;
        if (stalls != 2 || rom_data_o !== 32'h3C010101) begin
            tests_failed++;
            $display("FAIL zero_wait_hit: stalls=%0d data=%h want 2 3c010101", stalls, rom_data_o);
        end
    endtask

    task automatic test_misaligned();
        next_cycle();
        rom_ce_i = 1'b1; rom_addr_i = 32'h6;
        settle();
        tests_run++;
        if (mem_req_o !== 1'b0 || stall_req_o !== 1'b0 || rom_data_o !== 32'h0 || bus_err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL misaligned_same_cycle: req=%b stall=%b data=%h err=%b want 0 0 0 0",
                     mem_req_o, stall_req_o, rom_data_o, bus_err_o);
        end
        next_cycle();
        rom_addr_i = 32'h10;
        settle();
        tests_run++;
        if (bus_err_o !== 1'b1 || mem_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL misaligned_err: err=%b req=%b want 1 0", bus_err_o, mem_req_o);
        end
        tests_run++;
        if (rom_data_o !== 32'h3C010101 || stall_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL misaligned_buf_kept: data=%h stall=%b want 3c010101 0", rom_data_o, stall_req_o);
        end
        next_cycle();
        rom_ce_i = 1'b0;
        settle();
        tests_run++;
        if (rom_data_o !== 32'h0 || stall_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ce_low: data=%h stall=%b want 0 0", rom_data_o, stall_req_o);
        end
    endtask

    task automatic test_timeout();
        int req_cycles;
        req_cycles = 0;
        next_cycle();
        rom_ce_i = 1'b1; rom_addr_i = 32'h8;
        settle();
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            settle();
            if (mem_req_o !== 1'b1) break;
            req_cycles++;
        end
        tests_run++;
        if (req_cycles != 4) begin
            tests_failed++;
            $display("FAIL timeout_req_cycles: got %0d want 4", req_cycles);
        end
        tests_run++;
        if (rom_data_o !== 32'h0 || stall_req_o !== 1'b0 || bus_err_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_nop: data=%h stall=%b err=%b want 0 0 1",
                     rom_data_o, stall_req_o, bus_err_o);
        end
        next_cycle();
        rom_ce_i = 1'b0;
        next_cycle();
        settle();
        tests_run++;
        if (bus_err_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_sticky: err=%b want 1", bus_err_o);
        end
    endtask

    task automatic test_flush();
        // Flush one cycle before the ack.
        next_cycle();
        rom_ce_i = 1'b1; rom_addr_i = 32'h20;
        next_cycle();
        flush_i = 1'b1;
        next_cycle();
        flush_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        next_cycle();
        mem_ack_i = 1'b0;
        settle();
        tests_run++;
        if (stall_req_o !== 1'b1 || rom_data_o !== 32'h0 || mem_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_no_hit: stall=%b data=%h req=%b want 1 0 0",
                     stall_req_o, rom_data_o, mem_req_o);
        end
        next_cycle();
        settle();
        tests_run++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h20) begin
            tests_failed++;
            $display("FAIL flush_rerequest: req=%b addr=%h want 1 00000020", mem_req_o, mem_addr_o);
        end
        mem_ack_i = 1'b1; mem_rdata_i = 32'h11112222;
        next_cycle();
        mem_ack_i = 1'b0;
        settle();
        tests_run++;
        if (rom_data_o !== 32'h11112222 || stall_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_refill: data=%h stall=%b want 11112222 0", rom_data_o, stall_req_o);
        end
        // Flush coincident with the ack.
        rom_addr_i = 32'h24;
        next_cycle();
        flush_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
        next_cycle();
        flush_i = 1'b0; mem_ack_i = 1'b0;
        settle();
        tests_run++;
        if (stall_req_o !== 1'b1 || rom_data_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL flush_with_ack: stall=%b data=%h want 1 0", stall_req_o, rom_data_o);
        end
        next_cycle();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h55667788;
        next_cycle();
        mem_ack_i = 1'b0;
        settle();
        tests_run++;
        if (rom_data_o !== 32'h55667788 || stall_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_cleared: data=%h stall=%b want 55667788 0", rom_data_o, stall_req_o);
        end
    endtask

    task automatic test_reset_mid_busy();
        next_cycle();
        rom_ce_i = 1'b1; rom_addr_i = 32'h30;
        next_cycle();
        settle();
        tests_run++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h30) begin
            tests_failed++;
            $display("FAIL rmb_req_up: req=%b addr=%h want 1 00000030", mem_req_o, mem_addr_o);
        end
        rst = 1'b0;
        settle();
        tests_run++;
        if (stall_req_o !== 1'b0 || rom_data_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL rmb_outputs_in_reset: stall=%b data=%h want 0 0", stall_req_o, rom_data_o);
        end
        next_cycle();
        rst = 1'b1; rom_ce_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h99999999;
        settle();
        tests_run++;
        if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || bus_err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmb_req_dropped: req=%b addr=%h err=%b want 0 0 0",
                     mem_req_o, mem_addr_o, bus_err_o);
        end
        next_cycle();
        mem_ack_i = 1'b0; rom_ce_i = 1'b1; rom_addr_i = 32'h30;
        settle();
        tests_run++;
        if (stall_req_o !== 1'b1 || rom_data_o !== 32'h0 || mem_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmb_late_ack_ignored: stall=%b data=%h req=%b want 1 0 0",
                     stall_req_o, rom_data_o, mem_req_o);
        end
        next_cycle();
        rom_ce_i = 1'b0;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_miss_hit();
        test_zero_wait();
        test_misaligned();
        test_reset();
        test_timeout();
        test_flush();
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
